alu_muldiv_ctrl: RTL and testbench

//   Multi-cycle sequencer for the ALU's multiply/divide function and owner of the architectural HI/LO pair.

---
 rtl/alu_muldiv_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair: 32-step shift-add multiply, restoring divide.
// Optional feature macro: ALU_MULDIV_DIV0_TRAP_EN (divide-by-zero short-circuits to FIX and flags div0).
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  whi_q, whi_d, wlo_q, wlo_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic              is_div_q, is_div_d, trap_q, trap_d;
    logic              busy_q, busy_d, done_q, done_d, div0_q, div0_d;

    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] prod_s;

    // Operand magnitudes and one datapath step for each of multiply and divide
    always_comb begin
        mag_a_s     = (sign && A[WIDTH-1]) ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
        mag_b_s     = (sign && B[WIDTH-1]) ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
        mul_sum_s   = {1'b0, whi_q} + (wlo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {whi_q, wlo_q[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_q};
        prod_s      = {whi_q, wlo_q};
        if (neg_res_q) begin
            prod_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            prod_s = {whi_q, wlo_q};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        whi_d     = whi_q;
        wlo_d     = wlo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        trap_d    = trap_q;
        done_d    = 1'b0;
        div0_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = mag_a_s;
                    b_d       = mag_b_s;
                    neg_res_d = sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_rem_d = sign & A[WIDTH-1];
                    cnt_d     = {CNT_W{1'b0}};
                    whi_d     = {WIDTH{1'b0}};
                    trap_d    = 1'b0;
                    case (op)
                        OP_MULT: begin
                            wlo_d    = mag_b_s;
                            is_div_d = 1'b0;
                            state_d  = S_MUL;
                        end
                        OP_DIV: begin
                            wlo_d    = mag_a_s;
                            is_div_d = 1'b1;
`ifdef ALU_MULDIV_DIV0_TRAP_EN
                            if (B == {WIDTH{1'b0}}) begin
                                trap_d  = 1'b1;
                                state_d = S_FIX;
                            end else begin
                                state_d = S_DIV;
                            end
`else
                            state_d  = S_DIV;
`endif
                        end
                        OP_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                whi_d = mul_sum_s[WIDTH:1];
                wlo_d = {mul_sum_s[0], wlo_q[WIDTH-1:1]};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                // Restore (keep the shifted remainder) whenever the trial subtraction goes negative
                if (div_diff_s[WIDTH+1]) begin
                    whi_d = div_shift_s[WIDTH-1:0];
                end else begin
                    whi_d = div_diff_s[WIDTH-1:0];
                end
                wlo_d = {wlo_q[WIDTH-2:0], ~div_diff_s[WIDTH+1]};
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (trap_q) begin
                    div0_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_res_q ? (~wlo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : wlo_q;
                    hi_d = neg_rem_q ? (~whi_q + {{(WIDTH-1){1'b0}}, 1'b1}) : whi_q;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            whi_q     <= {WIDTH{1'b0}};
            wlo_q     <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            trap_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            whi_q     <= whi_d;
            wlo_q     <= wlo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            trap_q    <= trap_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign div0  = div0_q;
    assign outHI = hi_q;
    assign outLO = lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed self-checking bench for alu_muldiv_ctrl; expectations follow ALU_MULDIV_DIV0_TRAP_EN when defined.
module tb_alu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic        busy, done, div0;
    logic [31:0] outHI, outLO;

    int n_cmp = 0;
    int n_err = 0;

    alu_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
        .A(A), .B(B), .busy(busy), .done(done), .div0(div0),
        .outHI(outHI), .outLO(outLO)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then wait (bounded) for done; lat = edges after the start edge.
    task automatic run_op(input logic [1:0] o, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output logic overlap);
        op = o; sign = s; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h0000_0003;
        lat = 0;
        overlap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (busy && done) overlap = 1'b1;
            if (done) break;
        end
    endtask

    task automatic check_res(input string name, input int lat, input int exp_lat,
                             input logic overlap, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if ({outHI, outLO} !== {exp_hi, exp_lo}) begin
            n_err++;
            $display("FAIL %s result: got HI=%h LO=%h expected HI=%h LO=%h", name, outHI, outLO, exp_hi, exp_lo);
        end
        n_cmp++;
        if (overlap !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy/done: overlap=%b busy=%b expected 0 0", name, overlap, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, div0, outHI, outLO} !== {3'b000, 64'h0}) begin
            n_err++;
            $display("FAIL reset: got busy=%b done=%b div0=%b HI=%h LO=%h expected all 0", busy, done, div0, outHI, outLO);
        end
    endtask

    task automatic test_mult;
        int lat; logic ov;
        run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, lat, ov);
        check_res("mult_unsigned", lat, 33, ov, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op(2'b00, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, lat, ov);
        check_res("mult_signed_neg", lat, 33, ov, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op(2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, lat, ov);
        check_res("mult_signed_min", lat, 33, ov, 32'h4000_0000, 32'h0000_0000);
        run_op(2'b00, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, ov);
        check_res("mult_unsigned_min", lat, 33, ov, 32'h4000_0000, 32'h0000_0000);
    endtask

    task automatic test_div;
        int lat; logic ov;
        run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat, ov);
        check_res("div_signed_neg", lat, 33, ov, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(2'b01, 1'b0, 32'd100, 32'd7, lat, ov);
        check_res("div_unsigned", lat, 33, ov, 32'h0000_0002, 32'h0000_000E);
        run_op(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, ov);
        check_res("div_signed_overflow", lat, 33, ov, 32'h0000_0000, 32'h8000_0000);
        run_op(2'b01, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, ov);
        check_res("div_signed_negdivisor", lat, 33, ov, 32'h0000_0001, 32'hFFFF_FFFD);
    endtask

    task automatic test_div0;
        int lat; logic ov; logic saw_div0;
`ifdef ALU_MULDIV_DIV0_TRAP_EN
        run_op(2'b01, 1'b0, 32'd5, 32'd0, lat, ov);
        saw_div0 = div0;
        check_res("div0_trap", lat, 1, ov, 32'h0000_0001, 32'hFFFF_FFFD);
        n_cmp++;
        if (saw_div0 !== 1'b1) begin
            n_err++;
            $display("FAIL div0_flag: got %b expected 1", saw_div0);
        end
`else
        run_op(2'b01, 1'b0, 32'd5, 32'd0, lat, ov);
        saw_div0 = div0;
        check_res("div0_unsigned", lat, 33, ov, 32'h0000_0005, 32'hFFFF_FFFF);
        n_cmp++;
        if (saw_div0 !== 1'b0) begin
            n_err++;
            $display("FAIL div0_flag: got %b expected 0", saw_div0);
        end
        run_op(2'b01, 1'b1, 32'hFFFF_FFFB, 32'd0, lat, ov);
        check_res("div0_signed_neg", lat, 33, ov, 32'hFFFF_FFFB, 32'h0000_0001);
`endif
    endtask

    task automatic test_back_to_back;
        int lat; logic ov;
        run_op(2'b00, 1'b0, 32'd3, 32'd4, lat, ov);
        check_res("b2b_first", lat, 33, ov, 32'h0, 32'd12);
        run_op(2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ov);
        check_res("b2b_second", lat, 33, ov, 32'h0, 32'd1);
    endtask

    task automatic test_ignore_and_abort;
        int lat; logic seen_done;
        op = 2'b00; sign = 1'b0; A = 32'd6; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 2'b01; A = 32'd100; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 5;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (done) break;
        end
        check_res("ignored_start", lat, 33, 1'b0, 32'h0, 32'd42);
        op = 2'b00; A = 32'd9; B = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, outHI, outLO} !== {2'b00, 64'h0}) begin
            n_err++;
            $display("FAIL abort_reset: got busy=%b done=%b HI=%h LO=%h expected 0 0 0 0", busy, done, outHI, outLO);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: got activity=%b expected 0", seen_done);
        end
    endtask

    task automatic test_mthi_mtlo;
        logic b1, d1, b2, d2;
        op = 2'b10; A = 32'h1234_5678; start = 1'b1;
        tick();
        b1 = busy; d1 = done;
        op = 2'b11; A = 32'h0000_0009;
        tick();
        b2 = busy; d2 = done;
        start = 1'b0;
        n_cmp++;
        if ({b1, d1, b2, d2} !== 4'b0101) begin
            n_err++;
            $display("FAIL mt_flags: got busy/done %b%b %b%b expected 01 01", b1, d1, b2, d2);
        end
        n_cmp++;
        if ({outHI, outLO} !== {32'h1234_5678, 32'h0000_0009}) begin
            n_err++;
            $display("FAIL mt_values: got HI=%h LO=%h expected HI=12345678 LO=00000009", outHI, outLO);
        end
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL mt_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        // seed known HI/LO so the trapped divide can show they are preserved
        begin
            int lat; logic ov;
            run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat, ov);
            run_op(2'b01, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, ov);
        end
        test_div0();
        test_back_to_back();
        test_ignore_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
